// File: rtl/tcb_lite_lib_error_log.sv
// Default TCB-Lite sink: every accepted transfer gets an error response after DLY
// cycles, with optional backpressure, a saturating transfer counter and a first-access log.
module tcb_lite_lib_error_log #(
  parameter int unsigned    DLY  = 0,
  parameter int unsigned    WAIT = 0,
  parameter int unsigned    CNT  = 16,
  parameter int unsigned    ADR  = 32,
  parameter int unsigned    DAT  = 32,
  parameter int unsigned    STS  = 4,
  parameter logic [DAT-1:0] RDT  = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sub_vld,
  output logic           sub_rdy,
  input  logic           sub_req_wen,
  input  logic [ADR-1:0] sub_req_adr,
  output logic [DAT-1:0] sub_rsp_rdt,
  output logic [STS-1:0] sub_rsp_sts,
  output logic           sub_rsp_err,
  input  logic [STS-1:0] sts,
  input  logic           clr,
  output logic [CNT-1:0] cnt,
  output logic           log_vld,
  output logic [ADR-1:0] log_adr,
  output logic           log_wen
);

  logic trn;

  assign trn         = sub_vld & sub_rdy;
  assign sub_rsp_err = 1'b1;
  assign sub_rsp_rdt = RDT;

  // rdy depends only on the registered wait counter, so there is no vld->rdy path.
  if (WAIT == 0) begin : g_nowait
    assign sub_rdy = 1'b1;
  end else begin : g_wait
    localparam int unsigned WW = $clog2(WAIT + 1);
    logic [WW-1:0] wct_d, wct_q;

    always_comb begin
      wct_d = wct_q;
      if (trn)                wct_d = WW'(WAIT);
      else if (wct_q != '0)   wct_d = wct_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) wct_q <= '0;
      else      wct_q <= wct_d;
    end

    assign sub_rdy = (wct_q == '0);
  end

  if (DLY == 0) begin : g_nodly
    assign sub_rsp_sts = sts;
  end else begin : g_dly
    logic [STS-1:0] stg_d [DLY];
    logic [STS-1:0] stg_q [DLY];

    // Idle slots carry zero so nothing stale reaches the response port.
    always_comb begin
      stg_d[0] = trn ? sts : '0;
      for (int i = 1; i < DLY; i++) stg_d[i] = stg_q[i-1];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < DLY; i++) stg_q[i] <= '0;
      end else begin
        for (int i = 0; i < DLY; i++) stg_q[i] <= stg_d[i];
      end
    end

    assign sub_rsp_sts = stg_q[DLY-1];
  end

  logic [CNT-1:0] cnt_d, cnt_q;
  logic           log_vld_d, log_vld_q;
  logic [ADR-1:0] log_adr_d, log_adr_q;
  logic           log_wen_d, log_wen_q;

  // clr and trn in the same cycle: the transfer counts as the first after the clear.
  always_comb begin
    cnt_d     = clr ? '0   : cnt_q;
    log_vld_d = clr ? 1'b0 : log_vld_q;
    log_adr_d = log_adr_q;
    log_wen_d = log_wen_q;
    if (trn) begin
      if (cnt_d != '1) cnt_d = cnt_d + 1'b1;
      if (!log_vld_d) begin
        log_vld_d = 1'b1;
        log_adr_d = sub_req_adr;
        log_wen_d = sub_req_wen;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      log_vld_q <= 1'b0;
      log_adr_q <= '0;
      log_wen_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      log_vld_q <= log_vld_d;
      log_adr_q <= log_adr_d;
      log_wen_q <= log_wen_d;
    end
  end

  assign cnt     = cnt_q;
  assign log_vld = log_vld_q;
  assign log_adr = log_adr_q;
  assign log_wen = log_wen_q;

endmodule

// File: tb/tb_tcb_lite_lib_error_log.sv
// Bench for tcb_lite_lib_error_log: three configurations, response scoreboard plus
// directed counter/log/backpressure/reset checks.
module tb_tcb_lite_lib_error_log;

  localparam logic [31:0] RDT0 = 32'hDEAD_BEEF;
  localparam logic [31:0] RDT1 = 32'h1234_5678;
  localparam logic [31:0] RDT2 = 32'hA5A5_0001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // u0: DLY=0 WAIT=0 CNT=4, u1: DLY=2 WAIT=2, u2: DLY=2 WAIT=0
  logic        vld0 = 0, wen0 = 0, clr0 = 0, vld1 = 0, wen1 = 0, clr1 = 0, vld2 = 0, wen2 = 0, clr2 = 0;
  logic [15:0] adr0 = 0, adr1 = 0, adr2 = 0;
  logic [3:0]  sts0 = 0, sts1 = 0, sts2 = 0;
  logic        rdy0, rdy1, rdy2, err0, err1, err2, lv0, lv1, lv2, lw0, lw1, lw2;
  logic [31:0] rdt0, rdt1, rdt2;
  logic [3:0]  rs0, rs1, rs2;
  logic [15:0] la0, la1, la2;
  logic [3:0]  cnt0;
  logic [15:0] cnt1, cnt2;

  tcb_lite_lib_error_log #(.DLY(0), .WAIT(0), .CNT(4), .ADR(16), .DAT(32), .STS(4), .RDT(RDT0)) u0 (
    .clk(clk), .rst(rst), .sub_vld(vld0), .sub_rdy(rdy0), .sub_req_wen(wen0), .sub_req_adr(adr0),
    .sub_rsp_rdt(rdt0), .sub_rsp_sts(rs0), .sub_rsp_err(err0), .sts(sts0), .clr(clr0),
    .cnt(cnt0), .log_vld(lv0), .log_adr(la0), .log_wen(lw0));

  tcb_lite_lib_error_log #(.DLY(2), .WAIT(2), .CNT(16), .ADR(16), .DAT(32), .STS(4), .RDT(RDT1)) u1 (
    .clk(clk), .rst(rst), .sub_vld(vld1), .sub_rdy(rdy1), .sub_req_wen(wen1), .sub_req_adr(adr1),
    .sub_rsp_rdt(rdt1), .sub_rsp_sts(rs1), .sub_rsp_err(err1), .sts(sts1), .clr(clr1),
    .cnt(cnt1), .log_vld(lv1), .log_adr(la1), .log_wen(lw1));

  tcb_lite_lib_error_log #(.DLY(2), .WAIT(0), .CNT(16), .ADR(16), .DAT(32), .STS(4), .RDT(RDT2)) u2 (
    .clk(clk), .rst(rst), .sub_vld(vld2), .sub_rdy(rdy2), .sub_req_wen(wen2), .sub_req_adr(adr2),
    .sub_rsp_rdt(rdt2), .sub_rsp_sts(rs2), .sub_rsp_err(err2), .sts(sts2), .clr(clr2),
    .cnt(cnt2), .log_vld(lv2), .log_adr(la2), .log_wen(lw2));

  // Reference wait counter for u1 (WAIT=2)
  int m_wct;
  always @(posedge clk or negedge rst) begin
    if (!rst)                     m_wct <= 0;
    else if (vld1 && m_wct == 0)  m_wct <= 2;
    else if (m_wct > 0)           m_wct <= m_wct - 1;
  end

  typedef struct {int due; logic [3:0] sts;} exp_t;
  exp_t q0[$], q1[$], q2[$];

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      q0.delete(); q1.delete(); q2.delete();
    end else begin
      if (vld0) q0.push_back('{cyc, sts0});
      if (vld1) chk("rdy1_model", {31'd0, rdy1}, {31'd0, m_wct == 0});
      if (vld1 && m_wct == 0) q1.push_back('{cyc + 2, sts1});
      if (vld2) q2.push_back('{cyc + 2, sts2});
      if (q0.size() > 0 && q0[0].due == cyc) begin
        e = q0.pop_front();
        chk("rsp0_sts", {28'd0, rs0}, {28'd0, e.sts});
        chk("rsp0_err", {31'd0, err0}, 32'd1);
        chk("rsp0_rdt", rdt0, RDT0);
      end
      if (q1.size() > 0 && q1[0].due == cyc) begin
        e = q1.pop_front();
        chk("rsp1_sts", {28'd0, rs1}, {28'd0, e.sts});
        chk("rsp1_err", {31'd0, err1}, 32'd1);
        chk("rsp1_rdt", rdt1, RDT1);
      end
      if (q2.size() > 0 && q2[0].due == cyc) begin
        e = q2.pop_front();
        chk("rsp2_sts", {28'd0, rs2}, {28'd0, e.sts});
        chk("rsp2_err", {31'd0, err2}, 32'd1);
        chk("rsp2_rdt", rdt2, RDT2);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    step(2);
    chk("rst_cnt0", {28'd0, cnt0}, 32'd0);
    chk("rst_lv0", {31'd0, lv0}, 32'd0);
    chk("rst_la0", {16'd0, la0}, 32'd0);
    chk("rst_lw0", {31'd0, lw0}, 32'd0);
    chk("rst_rdy0", {31'd0, rdy0}, 32'd1);
    chk("rst_rdy1", {31'd0, rdy1}, 32'd1);
    chk("rst_rs1", {28'd0, rs1}, 32'd0);
    chk("rst_rs2", {28'd0, rs2}, 32'd0);
    rst = 1'b1;
    step(1);

    // DLY=0 read: same-cycle error response, log/count one cycle later
    vld0 = 1; adr0 = 16'h0040; wen0 = 0; sts0 = 4'd3;
    #1;
    chk("t1_rs", {28'd0, rs0}, 32'd3);
    chk("t1_err", {31'd0, err0}, 32'd1);
    chk("t1_rdt", rdt0, RDT0);
    step(1);
    vld0 = 0;
    chk("t1_cnt", {28'd0, cnt0}, 32'd1);
    chk("t1_lv", {31'd0, lv0}, 32'd1);
    chk("t1_la", {16'd0, la0}, 32'h40);
    chk("t1_lw", {31'd0, lw0}, 32'd0);

    // DLY=2 back-to-back
    for (int i = 1; i <= 3; i++) begin
      vld2 = 1; sts2 = 4'(i); adr2 = 16'(16'h10 + 4 * (i - 1)); wen2 = 1;
      step(1);
    end
    vld2 = 0;
    chk("t2_cnt", cnt2, 32'd3);
    chk("t2_la", {16'd0, la2}, 32'h10);
    chk("t2_rs_b", {28'd0, rs2}, 32'd2);
    step(1);
    chk("t2_rs_c", {28'd0, rs2}, 32'd3);

    // WAIT=2 with vld held for 9 cycles
    for (int i = 0; i < 9; i++) begin
      vld1 = 1; sts1 = 4'((i % 7) + 1); adr1 = 16'(16'h20 + i); wen1 = 0;
      chk("t3_rdy", {31'd0, rdy1}, {31'd0, (i % 3) == 0});
      step(1);
    end
    vld1 = 0;
    chk("t3_cnt", cnt1, 32'd3);
    chk("t3_la", {16'd0, la1}, 32'h20);

    // CNT=4 saturation, then clr together with a write
    for (int i = 0; i < 20; i++) begin
      vld0 = 1; adr0 = 16'(16'h44 + i); sts0 = 4'($urandom_range(0, 15)); wen0 = 1'(i);
      step(1);
    end
    vld0 = 0;
    chk("t4_sat", {28'd0, cnt0}, 32'd15);
    chk("t4_la_keep", {16'd0, la0}, 32'h40);
    clr0 = 1; vld0 = 1; wen0 = 1; adr0 = 16'h0080; sts0 = 4'd9;
    step(1);
    clr0 = 0; vld0 = 0;
    chk("t4_clr_cnt", {28'd0, cnt0}, 32'd1);
    chk("t4_clr_la", {16'd0, la0}, 32'h80);
    chk("t4_clr_lw", {31'd0, lw0}, 32'd1);
    chk("t4_clr_lv", {31'd0, lv0}, 32'd1);
    clr0 = 1;
    step(1);
    clr0 = 0;
    chk("t4_clr2_cnt", {28'd0, cnt0}, 32'd0);
    chk("t4_clr2_lv", {31'd0, lv0}, 32'd0);

    // Reset one cycle after a handshake on u1
    step(3);
    vld1 = 1; sts1 = 4'd5; adr1 = 16'h0030; wen1 = 1;
    chk("t5_rdy_pre", {31'd0, rdy1}, 32'd1);
    step(1);
    vld1 = 0;
    rst = 1'b0;
    #1;
    chk("t5_cnt", cnt1, 32'd0);
    chk("t5_lv", {31'd0, lv1}, 32'd0);
    chk("t5_la", {16'd0, la1}, 32'd0);
    chk("t5_lw", {31'd0, lw1}, 32'd0);
    chk("t5_rdy", {31'd0, rdy1}, 32'd1);
    chk("t5_rs", {28'd0, rs1}, 32'd0);
    step(1);
    chk("t5_rs_stale", {28'd0, rs1}, 32'd0);
    step(1);
    rst = 1'b1;
    vld1 = 1; sts1 = 4'd6; adr1 = 16'h0034; wen1 = 0;
    chk("t5_rdy_rel", {31'd0, rdy1}, 32'd1);
    chk("t5_rs_rel", {28'd0, rs1}, 32'd0);
    step(1);
    vld1 = 0;
    chk("t5_cnt_rel", cnt1, 32'd1);
    chk("t5_la_rel", {16'd0, la1}, 32'h34);
    chk("t5_lv_rel", {31'd0, lv1}, 32'd1);
    chk("t5_rs_rel1", {28'd0, rs1}, 32'd0);
    step(1);
    chk("t5_rs_new", {28'd0, rs1}, 32'd6);

    step(3);
    chk("q0_drain", q0.size(), 32'd0);
    chk("q1_drain", q1.size(), 32'd0);
    chk("q2_drain", q2.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
